rojo_wb_master: RTL and testbench

//  Wishbone classic single-cycle bus initiator that drives the rojobot controller's wb_* slave port.

---
 rtl/rojo_wb_pkg.sv | 24 ++
 rtl/rojo_wb_cmd_fifo.sv | 49 ++++
 rtl/rojo_wb_master.sv | 149 ++++++++++++++
 tb/tb_rojo_wb_master.sv | 528 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rojo_wb_pkg.sv
// rojo_wb_pkg: shared types and constants for the rojobot Wishbone bus initiator
package rojo_wb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = WB_DAT_W / 8;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } rojo_wb_state_t;

    typedef struct packed {
        logic                we;
        logic [WB_ADR_W-1:0] adr;
        logic [WB_DAT_W-1:0] dat;
        logic [WB_SEL_W-1:0] sel;
    } rojo_wb_cmd_t;

endpackage

// File: rtl/rojo_wb_cmd_fifo.sv
// rojo_wb_cmd_fifo: 2-entry command buffer between the command stream and the bus FSM
module rojo_wb_cmd_fifo
    import rojo_wb_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  rojo_wb_cmd_t din_i,
    input  logic         pop_i,
    output rojo_wb_cmd_t dout_o,
    output logic         full_o,
    output logic         empty_o
);

    rojo_wb_cmd_t mem_q [2];
    logic [1:0]   cnt_q;
    logic         wp_q;
    logic         rp_q;
    logic         do_push;
    logic         do_pop;

    // occupancy flags; a push into a full buffer is accepted only alongside a pop
    always_comb begin
        empty_o = cnt_q == 2'd0;
        full_o  = cnt_q == 2'd2;
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        dout_o  = mem_q[rp_q];
    end

    // storage needs no reset: pointers and occupancy alone decide what is valid
    always_ff @(posedge clk) begin
        if (do_push && !rst) mem_q[wp_q] <= din_i;
    end

    // pointers and occupancy; reset flushes the buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 2'd0;
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
        end else begin
            if (do_push) wp_q <= ~wp_q;
            if (do_pop) rp_q <= ~rp_q;
            cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/rojo_wb_master.sv
// rojo_wb_master: Wishbone classic initiator fed by a valid/ready command stream; WB_TIMEOUT_EN adds a WAIT timeout
module rojo_wb_master
    import rojo_wb_pkg::*;
#(
    parameter int   ADR_W          = WB_ADR_W,
    parameter int   DAT_W          = WB_DAT_W,
    parameter int   TIMEOUT_CYCLES = 256,
    localparam int  SEL_W          = DAT_W / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [ADR_W-1:0] cmd_adr,
    input  logic [DAT_W-1:0] cmd_dat,
    input  logic [SEL_W-1:0] cmd_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DAT_W-1:0] rsp_dat,
    output logic             rsp_err,
    output logic             rsp_timeout,
    output logic [ADR_W-1:0] wb_adr_o,
    output logic [DAT_W-1:0] wb_dat_o,
    output logic [SEL_W-1:0] wb_sel_o,
    output logic             wb_we_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic [2:0]       wb_cti_o,
    output logic [1:0]       wb_bte_o,
    input  logic [DAT_W-1:0] wb_dat_i,
    input  logic             wb_ack_i,
    input  logic             wb_err_i
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("rojo_wb_master: TIMEOUT_CYCLES must be at least 1");
    end

    rojo_wb_state_t   state_q;
    rojo_wb_state_t   state_d;
    rojo_wb_cmd_t     cmd_in;
    rojo_wb_cmd_t     cmd_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             start;
    logic             ack_any;
    logic             tmo;
    logic             term;
    logic             we_q;
    logic [ADR_W-1:0] adr_q;
    logic [DAT_W-1:0] dat_q;
    logic [SEL_W-1:0] sel_q;
    logic [DAT_W-1:0] rsp_dat_q;
    logic             rsp_err_q;
    logic             rsp_tmo_q;

    // command intake and cycle start/termination conditions
    always_comb begin
        cmd_ready = !rst && !fifo_full;
        cmd_in    = '{we: cmd_we, adr: cmd_adr, dat: cmd_dat, sel: cmd_sel};
        start     = state_q == IDLE && !fifo_empty;
        ack_any   = wb_ack_i || wb_err_i;
        term      = state_q == WAIT && (ack_any || tmo);
    end

    rojo_wb_cmd_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_valid && cmd_ready),
        .din_i   (cmd_in),
        .pop_i   (start),
        .dout_o  (cmd_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef WB_TIMEOUT_EN
    localparam int CLOG  = $clog2(TIMEOUT_CYCLES);
    localparam int CNT_W = CLOG < 8 ? 8 : (CLOG > 32 ? 32 : CLOG);

    logic [CNT_W-1:0] cnt_q;

    // counts cycles spent in WAIT; held at zero everywhere else
    always_ff @(posedge clk) begin
        if (rst || state_q != WAIT) cnt_q <= '0;
        else cnt_q <= cnt_q + 1'b1;
    end

    // a real ack/err on the final count wins over the timeout
    always_comb tmo = state_q == WAIT && !ack_any && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
`else
    always_comb tmo = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        state_q <= rst ? IDLE : state_d;
    end

    // next state: one bus cycle at a time, response must drain before the next pop
    always_comb begin
        state_d = start ? WAIT :
                  term ? RESP :
                  (state_q == RESP && rsp_ready) ? IDLE : state_q;
    end

    // outputs decoded from state and the bus/response registers
    always_comb begin
        wb_cyc_o    = state_q == WAIT;
        wb_stb_o    = state_q == WAIT;
        rsp_valid   = state_q == RESP;
        wb_we_o     = we_q;
        wb_adr_o    = adr_q;
        wb_dat_o    = dat_q;
        wb_sel_o    = sel_q;
        wb_cti_o    = WB_CTI_CLASSIC;
        wb_bte_o    = WB_BTE_LINEAR;
        rsp_dat     = rsp_dat_q;
        rsp_err     = rsp_err_q;
        rsp_timeout = rsp_tmo_q;
    end

    // bus fields load on pop and stay put through WAIT; response fields capture at termination
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
            rsp_tmo_q <= 1'b0;
        end else begin
            if (start) begin
                we_q  <= cmd_head.we;
                adr_q <= cmd_head.adr;
                dat_q <= cmd_head.dat;
                sel_q <= cmd_head.sel;
            end
            if (term) begin
                rsp_dat_q <= (we_q || tmo) ? '0 : wb_dat_i;
                rsp_err_q <= wb_err_i || tmo;
                rsp_tmo_q <= tmo;
            end
        end
    end

endmodule

// File: tb/tb_rojo_wb_master.sv
// tb_rojo_wb_master: directed and randomized checks of rojo_wb_master against a transaction-level model
module tb_rojo_wb_master;

    localparam int TMO = 16;
    localparam int N   = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rojo_wb_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_adr     (cmd_adr),
        .cmd_dat     (cmd_dat),
        .cmd_sel     (cmd_sel),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_dat     (rsp_dat),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_sel_o    (wb_sel_o),
        .wb_we_o     (wb_we_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_cti_o    (wb_cti_o),
        .wb_bte_o    (wb_bte_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i),
        .wb_err_i    (wb_err_i)
    );

    // slave model: terminates after a programmable number of wait cycles (kind 0 ack, 1 err, 2 both)
    int          g_wait = 0;
    int          g_kind = 0;
    logic [31:0] g_dat = '0;
    logic        g_silent = 1'b0;
    logic        force_ack = 1'b0;
    logic        rnd = 1'b0;
    int          rw [64];
    int          rk [64];
    logic [31:0] rd [64];
    int          wcnt = 0;
    int          bus_idx = 0;
    int          base = 0;
    int          cur_w;
    int          cur_k;
    logic [31:0] cur_d;
    logic        resp_now;

    always_comb begin
        cur_w    = rnd ? rw[(bus_idx - base) & 63] : g_wait;
        cur_k    = rnd ? rk[(bus_idx - base) & 63] : g_kind;
        cur_d    = rnd ? rd[(bus_idx - base) & 63] : g_dat;
        resp_now = wb_cyc_o && wb_stb_o && !g_silent && wcnt == cur_w;
        wb_ack_i = force_ack || (resp_now && cur_k != 1);
        wb_err_i = resp_now && cur_k != 0;
        wb_dat_i = cur_d;
    end

    always @(posedge clk) begin
        wcnt <= (wb_cyc_o && !(wb_ack_i || wb_err_i)) ? wcnt + 1 : 0;
        if (wb_cyc_o && (wb_ack_i || wb_err_i)) bus_idx <= bus_idx + 1;
    end

    // offers one command from a negedge; returns at the negedge after the accepting edge
    task automatic send_cmd(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = a;
        cmd_dat   = d;
        cmd_sel   = s;
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            tests++;
            fails++;
            $display("FAIL send_cmd: cmd_ready stayed 0 for %0d cycles, required 1", n);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    // walks negedges until rsp_valid, measuring how long cyc was high and the fields it carried
    task automatic watch(output int len, output logic [68:0] f);
        int n = 0;
        len = 0;
        f   = '0;
        while (!rsp_valid && n < 600) begin
            if (wb_cyc_o) begin
                if (len == 0) f = {wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o};
                len++;
            end
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            tests++;
            fails++;
            $display("FAIL watch: rsp_valid still 0 after %0d cycles, required 1", n);
        end
    endtask

    // waits for a response, samples it and consumes it with a one-cycle rsp_ready
    task automatic take_rsp(output logic [31:0] d, output logic e, output logic t);
        int n = 0;
        while (!rsp_valid && n < 600) begin
            @(negedge clk);
            n++;
        end
        d = rsp_dat;
        e = rsp_err;
        t = rsp_timeout;
        if (!rsp_valid) begin
            tests++;
            fails++;
            $display("FAIL take_rsp: rsp_valid still 0 after %0d cycles, required 1", n);
        end else begin
            rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({cmd_ready, wb_cyc_o, wb_stb_o, rsp_valid, rsp_err, rsp_timeout, wb_we_o} !== 7'b0) begin
            fails++;
            $display("FAIL reset_ctl: got %b, required 0000000", {cmd_ready, wb_cyc_o, wb_stb_o, rsp_valid, rsp_err, rsp_timeout, wb_we_o});
        end
        tests++;
        if ({wb_adr_o, wb_dat_o, wb_sel_o, rsp_dat, wb_cti_o, wb_bte_o} !== 105'b0) begin
            fails++;
            $display("FAIL reset_data: adr %h dat %h sel %h rsp %h cti %b bte %b, required all 0", wb_adr_o, wb_dat_o, wb_sel_o, rsp_dat, wb_cti_o, wb_bte_o);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({cmd_ready, wb_cyc_o} !== 2'b10) begin
            fails++;
            $display("FAIL reset_release: cmd_ready/cyc %b, required 10", {cmd_ready, wb_cyc_o});
        end
    endtask

    task automatic test_write_zero_wait();
        logic [31:0] d;
        logic        e;
        logic        t;
        g_wait = 0;
        g_kind = 0;
        send_cmd(1'b1, 32'h0000_000C, 32'hDEAD_BEEF, 4'hF);
        tests++;
        if (wb_cyc_o !== 1'b0) begin
            fails++;
            $display("FAIL wr_latency: cyc %b one cycle after accept, required 0", wb_cyc_o);
        end
        @(negedge clk);
        tests++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o, wb_bte_o} !== {3'b111, 32'h0000_000C, 32'hDEAD_BEEF, 4'hF, 5'b0}) begin
            fails++;
            $display("FAIL wr_bus: cyc%b stb%b we%b adr %h dat %h sel %h cti %b bte %b, required 111 0000000c deadbeef f 000 00", wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o, wb_bte_o);
        end
        @(negedge clk);
        tests++;
        if ({wb_cyc_o, rsp_valid, rsp_err, rsp_timeout, rsp_dat} !== {4'b0100, 32'h0}) begin
            fails++;
            $display("FAIL wr_rsp: cyc%b valid%b err%b tmo%b dat %h, required 0 1 0 0 00000000", wb_cyc_o, rsp_valid, rsp_err, rsp_timeout, rsp_dat);
        end
        take_rsp(d, e, t);
        tests++;
        if (rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL wr_consume: rsp_valid %b after handshake, required 0", rsp_valid);
        end
    endtask

    task automatic test_read_wait5();
        int          len;
        logic [68:0] f;
        logic [31:0] d;
        logic        e;
        logic        t;
        g_wait = 5;
        g_kind = 0;
        g_dat  = 32'h1234_5678;
        send_cmd(1'b0, 32'h0000_0004, 32'h0, 4'hF);
        watch(len, f);
        tests++;
        if (len != 6) begin
            fails++;
            $display("FAIL rd_cyc_len: cyc high %0d cycles, required 6", len);
        end
        tests++;
        if (f !== {1'b0, 32'h0000_0004, 32'h0, 4'hF}) begin
            fails++;
            $display("FAIL rd_bus: fields %h, required %h", f, {1'b0, 32'h0000_0004, 32'h0, 4'hF});
        end
        take_rsp(d, e, t);
        tests++;
        if ({d, e, t} !== {32'h1234_5678, 2'b00}) begin
            fails++;
            $display("FAIL rd_rsp: dat %h err %b tmo %b, required 12345678 0 0", d, e, t);
        end
    endtask

    task automatic test_back_to_back();
        int          viol = 0;
        logic [31:0] d;
        logic        e;
        logic        t;
        logic [31:0] exp_d [3];
        g_wait = 0;
        g_kind = 0;
        g_dat  = 32'h5A5A_A5A5;
        exp_d  = '{32'h5A5A_A5A5, 32'h0, 32'h5A5A_A5A5};
        rsp_ready = 1'b0;
        send_cmd(1'b0, 32'h10, 32'h0, 4'hF);
        send_cmd(1'b1, 32'h14, 32'h1111_2222, 4'h3);
        send_cmd(1'b0, 32'h18, 32'h0, 4'hC);
        tests++;
        if ({cmd_ready, rsp_valid} !== 2'b01) begin
            fails++;
            $display("FAIL b2b_full: cmd_ready/rsp_valid %b after 3rd push, required 01", {cmd_ready, rsp_valid});
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wb_cyc_o || cmd_ready || !rsp_valid) viol++;
        end
        tests++;
        if (viol != 0) begin
            fails++;
            $display("FAIL b2b_stall: %0d cycles with a bus cycle or free slot while stalled, required 0", viol);
        end
        for (int i = 0; i < 3; i++) begin
            take_rsp(d, e, t);
            tests++;
            if ({d, e, t} !== {exp_d[i], 2'b00}) begin
                fails++;
                $display("FAIL b2b_rsp%0d: dat %h err %b tmo %b, required %h 0 0", i, d, e, t, exp_d[i]);
            end
        end
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_drain: cmd_ready %b after drain, required 1", cmd_ready);
        end
    endtask

    task automatic test_ack_err();
        int          len;
        logic [68:0] f;
        logic [31:0] d;
        logic        e;
        logic        t;
        g_wait = 2;
        g_kind = 2;
        g_dat  = 32'hCAFE_F00D;
        send_cmd(1'b0, 32'h40, 32'h0, 4'h1);
        watch(len, f);
        tests++;
        if (len != 3) begin
            fails++;
            $display("FAIL ackerr_len: cyc high %0d cycles, required 3", len);
        end
        take_rsp(d, e, t);
        tests++;
        if ({d, e, t} !== {32'hCAFE_F00D, 2'b10}) begin
            fails++;
            $display("FAIL ackerr_rsp: dat %h err %b tmo %b, required cafef00d 1 0", d, e, t);
        end
        g_kind = 0;
    endtask

`ifdef WB_TIMEOUT_EN
    task automatic test_timeout();
        int          len;
        logic [68:0] f;
        logic [31:0] d;
        logic        e;
        logic        t;
        g_silent = 1'b1;
        g_dat    = 32'hFFFF_0000;
        send_cmd(1'b0, 32'h80, 32'h0, 4'hF);
        watch(len, f);
        tests++;
        if (len != TMO) begin
            fails++;
            $display("FAIL tmo_len: cyc high %0d cycles, required %0d", len, TMO);
        end
        take_rsp(d, e, t);
        tests++;
        if ({d, e, t} !== {32'h0, 2'b11}) begin
            fails++;
            $display("FAIL tmo_rsp: dat %h err %b tmo %b, required 00000000 1 1", d, e, t);
        end
        g_silent = 1'b0;
    endtask
`else
    task automatic test_no_timeout();
        int          hi = 0;
        logic [31:0] d;
        logic        e;
        logic        t;
        g_silent = 1'b1;
        g_dat    = 32'h0BAD_F00D;
        send_cmd(1'b0, 32'h20, 32'h0, 4'hF);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (wb_cyc_o && !rsp_valid) hi++;
        end
        tests++;
        if (hi != 300) begin
            fails++;
            $display("FAIL notmo_hold: cyc held %0d of 300 cycles, required 300", hi);
        end
        force_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        force_ack = 1'b0;
        g_silent  = 1'b0;
        take_rsp(d, e, t);
        tests++;
        if ({d, e, t} !== {32'h0BAD_F00D, 2'b00}) begin
            fails++;
            $display("FAIL notmo_rsp: dat %h err %b tmo %b, required 0badf00d 0 0", d, e, t);
        end
    endtask
`endif

    task automatic test_reset_mid_wait();
        int viol = 0;
        g_silent = 1'b1;
        send_cmd(1'b1, 32'h100, 32'h7777_8888, 4'hF);
        send_cmd(1'b0, 32'h104, 32'h0, 4'hF);
        tests++;
        if (wb_cyc_o !== 1'b1) begin
            fails++;
            $display("FAIL rstw_busy: cyc %b with first cmd on the bus, required 1", wb_cyc_o);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if ({wb_cyc_o, wb_stb_o, rsp_valid, cmd_ready} !== 4'b0000) begin
            fails++;
            $display("FAIL rstw_drop: cyc/stb/valid/ready %b during reset, required 0000", {wb_cyc_o, wb_stb_o, rsp_valid, cmd_ready});
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({cmd_ready, wb_cyc_o} !== 2'b10) begin
            fails++;
            $display("FAIL rstw_release: cmd_ready/cyc %b, required 10", {cmd_ready, wb_cyc_o});
        end
        force_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        force_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (wb_cyc_o || rsp_valid) viol++;
            @(negedge clk);
        end
        tests++;
        if (viol != 0) begin
            fails++;
            $display("FAIL rstw_flush: %0d cycles with cyc or rsp_valid after reset, required 0", viol);
        end
        g_silent = 1'b0;
    endtask

    task automatic test_random();
        logic        cw [N];
        logic [31:0] ca [N];
        logic [31:0] cd [N];
        logic [3:0]  cs [N];
        logic [31:0] ed [N];
        logic        ee [N];
        for (int i = 0; i < N; i++) begin
            cw[i] = 1'($urandom_range(0, 1));
            ca[i] = $urandom & 32'hFFFF_FFFC;
            cd[i] = $urandom;
            cs[i] = 4'($urandom_range(1, 15));
            rw[i] = $urandom_range(0, 3);
            rk[i] = $urandom_range(0, 2);
            rd[i] = $urandom;
            ed[i] = cw[i] ? 32'h0 : rd[i];
            ee[i] = rk[i] != 0;
        end
        base = bus_idx;
        rnd  = 1'b1;
        fork
            begin
                for (int i = 0; i < N; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    send_cmd(cw[i], ca[i], cd[i], cs[i]);
                end
            end
            begin
                int   j = 0;
                int   len = 0;
                int   gap = 99;
                int   n = 0;
                logic prev = 1'b0;
                while (j < N && n < 4000) begin
                    @(negedge clk);
                    n++;
                    if (wb_cyc_o && !prev) begin
                        tests++;
                        if ({wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o} !== {cw[j], ca[j], cd[j], cs[j]} || gap < 2) begin
                            fails++;
                            $display("FAIL rnd_bus%0d: fields %h gap %0d, required %h gap>=2", j, {wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o}, gap, {cw[j], ca[j], cd[j], cs[j]});
                        end
                        len = 1;
                    end else if (wb_cyc_o) begin
                        len++;
                    end else if (prev) begin
                        tests++;
                        if (len != rw[j] + 1) begin
                            fails++;
                            $display("FAIL rnd_len%0d: cyc high %0d cycles, required %0d", j, len, rw[j] + 1);
                        end
                        j++;
                        gap = 1;
                    end else begin
                        gap++;
                    end
                    prev = wb_cyc_o;
                end
                if (j < N) begin
                    tests++;
                    fails++;
                    $display("FAIL rnd_monitor: saw %0d bus cycles, required %0d", j, N);
                end
            end
            begin
                int   k = 0;
                int   n = 0;
                logic r;
                while (k < N && n < 4000) begin
                    @(negedge clk);
                    n++;
                    r = 1'($urandom_range(0, 1));
                    rsp_ready = r;
                    if (rsp_valid && r) begin
                        tests++;
                        if ({rsp_dat, rsp_err, rsp_timeout} !== {ed[k], ee[k], 1'b0}) begin
                            fails++;
                            $display("FAIL rnd_rsp%0d: dat %h err %b tmo %b, required %h %b 0", k, rsp_dat, rsp_err, rsp_timeout, ed[k], ee[k]);
                        end
                        k++;
                    end
                end
                if (k < N) begin
                    tests++;
                    fails++;
                    $display("FAIL rnd_consumer: took %0d responses, required %0d", k, N);
                end
            end
        join
        @(negedge clk);
        rsp_ready = 1'b0;
        rnd = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait5();
        test_back_to_back();
        test_ack_err();
`ifdef WB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
